// File: rtl/mul_slice_unit.sv
// Multi-cycle sliced RV32M multiplier: LANES slice products per pass, B rotates one slice per pass.
// Optional MUL_FAST_ZERO_EN: a zero operand bypasses CALC/DRAIN and returns 0 one cycle after accept.
module mul_slice_unit #(
  parameter int XLEN    = 32,
  parameter int SLICE_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam int LANES = XLEN / SLICE_W;
  localparam int CW    = (LANES > 2) ? $clog2(LANES) : 1;
  localparam int PW    = 2 * SLICE_W + 2;
  localparam int AW    = 2 * XLEN;

  if ((XLEN % SLICE_W) != 0 || LANES < 2) begin : g_bad_cfg
    $error("mul_slice_unit: XLEN must be a multiple of SLICE_W with at least two slices");
  end

  typedef enum logic [1:0] {IDLE, CALC, DRAIN, DONE} state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q, cnt1_q;
  logic [1:0]            drn_q;
  logic [1:0]            op_q;
  logic [XLEN-1:0]       a_q, b_q;
  logic                  a_sgn_q;
  logic [LANES-1:0]      bsgn_q;
  logic                  vld1_q, vld2_q;
  logic signed [PW-1:0]  prod_q [LANES];
  logic [AW-1:0]         sum_q, acc_q;
  logic [XLEN-1:0]       result_q;
  logic                  in_ready_q, out_valid_q;

  logic signed [PW-1:0]  prod_d [LANES];
  logic [AW-1:0]         sum_d;
  logic                  zero_ops;
  logic                  a_sgn_d, b_sgn_d;

  assign a_sgn_d = (op_i == 2'b01) || (op_i == 2'b10);
  assign b_sgn_d = (op_i == 2'b01);

`ifdef MUL_FAST_ZERO_EN
  assign zero_ops = (op_a_i == '0) || (op_b_i == '0);
`else
  assign zero_ops = 1'b0;
`endif

  // Only the top slice of a signed operand carries a sign bit; all others are zero-extended.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam logic TOP = (g == LANES - 1);
    logic signed [SLICE_W:0] ea, eb;
    assign ea = {TOP & a_sgn_q & a_q[(g+1)*SLICE_W-1], a_q[g*SLICE_W +: SLICE_W]};
    assign eb = {bsgn_q[g] & b_q[(g+1)*SLICE_W-1], b_q[g*SLICE_W +: SLICE_W]};
    assign prod_d[g] = PW'(ea) * PW'(eb);
  end

  // Lane i in pass p holds B slice (i - p) mod LANES after p left rotations.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_d = sum_d + (AW'(prod_q[i]) << (SLICE_W * (i + ((i + LANES - int'(cnt1_q)) % LANES))));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cnt1_q      <= '0;
      drn_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      a_sgn_q     <= 1'b0;
      bsgn_q      <= '0;
      vld1_q      <= 1'b0;
      vld2_q      <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
      sum_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      vld1_q <= (state_q == CALC) && !flush_i;
      cnt1_q <= cnt_q;
      for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
      vld2_q <= vld1_q && !flush_i;
      sum_q  <= sum_d;
      if (vld2_q && !flush_i) acc_q <= acc_q + sum_q;

      if (flush_i) begin
        state_q     <= IDLE;
        in_ready_q  <= 1'b1;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (in_valid_i) begin
            op_q       <= op_i;
            a_q        <= op_a_i;
            b_q        <= op_b_i;
            a_sgn_q    <= a_sgn_d;
            bsgn_q     <= {b_sgn_d, {(LANES-1){1'b0}}};
            cnt_q      <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            // Fast-zero enters DRAIN on its last count so DONE follows one edge later.
            if (zero_ops) begin
              state_q <= DRAIN;
              drn_q   <= 2'd2;
            end else begin
              state_q <= CALC;
              drn_q   <= 2'd0;
            end
          end
          CALC: begin
            b_q    <= {b_q[XLEN-SLICE_W-1:0], b_q[XLEN-1 -: SLICE_W]};
            bsgn_q <= {bsgn_q[LANES-2:0], bsgn_q[LANES-1]};
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CW'(LANES - 1)) state_q <= DRAIN;
          end
          DRAIN: begin
            drn_q <= drn_q + 2'd1;
            if (drn_q == 2'd2) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= (op_q == 2'b00) ? acc_q[XLEN-1:0] : acc_q[AW-1:XLEN];
            end
          end
          DONE: if (out_ready_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;

endmodule

// File: tb/tb_mul_slice_unit.sv
// Directed + randomized bench for mul_slice_unit against a 64-bit arithmetic reference.
module tb_mul_slice_unit;
  localparam int XLEN    = 32;
  localparam int SLICE_W = 8;
  localparam int LANES   = XLEN / SLICE_W;
`ifdef MUL_FAST_ZERO_EN
  localparam bit FZ = 1'b1;
`else
  localparam bit FZ = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      op = 2'b00;
  logic [XLEN-1:0] a = '0, b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;

  int vecs = 0;
  int miscmp = 0;

  mul_slice_unit #(.XLEN(XLEN), .SLICE_W(SLICE_W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .op_a_i(a), .op_b_i(b),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ex, ey, p;
    ex = (o == 2'b01 || o == 2'b10) ? {{32{x[31]}}, x} : {32'h0, x};
    ey = (o == 2'b01) ? {{32{y[31]}}, y} : {32'h0, y};
    p  = ex * ey;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    in_valid = 1'b1; op = o; a = x; b = y;
    tick();
    in_valid = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  // Returns cycles from accept until out_valid; flags in_ready seen high meanwhile.
  task automatic wait_result(output int lat, output logic rdy_seen);
    lat = 0; rdy_seen = 1'b0;
    while (!out_valid && lat < 60) begin
      if (in_ready) rdy_seen = 1'b1;
      tick(); lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp);
    int lat; logic rs; int exp_lat;
    issue(o, x, y);
    wait_result(lat, rs);
    exp_lat = (FZ && (x == 0 || y == 0)) ? 1 : LANES + 3;
    chk({tag, "_res"}, result, exp);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int lat; logic rs, stable, bad; logic [31:0] held, x, y; logic [1:0] o;

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_result", result, 32'h0);

    issue(2'b00, 32'd7, 32'd6);
    wait_result(lat, rs);
    chk("mul7x6_res", result, 32'h2A);
    chk("mul7x6_lat", 32'(lat), 32'(LANES + 3));
    chk("mul7x6_busy", {31'h0, rs}, 32'h0);

    run_op("mulh_min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
    run_op("mulhu_ff", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("mulhsu_ff", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("mul_ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);

    // Backpressure: result must hold while the consumer stalls.
    tick();
    out_ready = 1'b0;
    issue(2'b01, 32'h12345678, 32'h9ABCDEF0);
    wait_result(lat, rs);
    held = result;
    chk("bp_res", result, ref_mul(2'b01, 32'h12345678, 32'h9ABCDEF0));
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    chk("bp_stable", {31'h0, stable}, 32'h1);
    out_ready = 1'b1;
    tick();
    chk("bp_valid_drop", {31'h0, out_valid}, 32'h0);
    chk("bp_ready_rise", {31'h0, in_ready}, 32'h1);
    run_op("b2b", 2'b00, 32'd1000, 32'd1000, 32'd1000000);

    // Flush during the third CALC cycle.
    tick();
    issue(2'b00, $urandom, $urandom);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ready", {31'h0, in_ready}, 32'h1);
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) bad = 1'b1;
      tick();
    end
    chk("flush_no_valid", {31'h0, bad}, 32'h0);
    in_valid = 1'b1; flush = 1'b1; a = 32'd9; b = 32'd9;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_blocks_accept", {31'h0, in_ready}, 32'h1);
    run_op("mul3x5", 2'b00, 32'd3, 32'd5, 32'hF);

    // Reset in the middle of DRAIN.
    tick();
    issue(2'b11, 32'hDEADBEEF, 32'hCAFEF00D);
    repeat (LANES + 1) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_ready", {31'h0, in_ready}, 32'h1);
    chk("rstmid_valid", {31'h0, out_valid}, 32'h0);
    chk("rstmid_result", result, 32'h0);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) bad = 1'b1;
      tick();
    end
    chk("rstmid_no_valid", {31'h0, bad}, 32'h0);
    run_op("mulhu_2p16", 2'b11, 32'h00010000, 32'h00010000, 32'h1);

    run_op("zero_a", 2'b00, 32'h0, 32'h1234, 32'h0);

    for (int k = 0; k < 40; k++) begin
      o = 2'($urandom);
      x = pick();
      y = pick();
      out_ready = ($urandom_range(0, 3) != 0);
      issue(o, x, y);
      wait_result(lat, rs);
      chk("rand_res", result, ref_mul(o, x, y));
      chk("rand_lat", 32'(lat), 32'((FZ && (x == 0 || y == 0)) ? 1 : LANES + 3));
      if (!out_ready) begin
        repeat ($urandom_range(1, 4)) tick();
        chk("rand_hold", result, ref_mul(o, x, y));
        out_ready = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
